// File: rtl/load_store_unit.sv
// Load/store unit: multi-cycle initiator between the execute stage and a
// handshaked data memory. Aligns store data into byte lanes, generates write
// strobes, sign/zero-extends load data, and stalls the core while in flight.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_i, we_i           access request (sampled in idle), 1 = store
//   funct3_i              RV32I size/sign code
//   addr_i, wdata_i       byte address and store data (rs2)
//   stall_o               freeze the pipeline while the access is pending
//   done_o, err_o         one-cycle completion / illegal-access pulses
//   rdata_o               registered, extended load result
//   mem_*                 valid/ready data-memory request channel
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

    state_e                state_q, state_d;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [3:0]            mem_wstrb_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  legal;
    logic [3:0]            wstrb_fmt;
    logic [DATA_WIDTH-1:0] wdata_fmt;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] rdata_fmt;
    logic                  accept;

    // Legality of the incoming access: funct3 code and natural alignment.
    always_comb begin
        legal = 1'b0;
        case (funct3_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr_i[0];
            3'b010:  legal = (addr_i[1:0] == 2'b00);
            3'b100:  legal = ~we_i;
            3'b101:  legal = ~we_i & ~addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    // Store lane replication; the strobes select which replica is written.
    always_comb begin
        wstrb_fmt = 4'b0000;
        wdata_fmt = '0;
        if (we_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    wstrb_fmt = 4'b0001 << addr_i[1:0];
                    wdata_fmt = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    wstrb_fmt = 4'b0011 << addr_i[1:0];
                    wdata_fmt = {2{wdata_i[15:0]}};
                end
                default: begin
                    wstrb_fmt = 4'b1111;
                    wdata_fmt = wdata_i;
                end
            endcase
        end
    end

    // Load extraction from the latched byte offset.
    always_comb begin
        rdata_shift = mem_rdata_i >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  rdata_fmt = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b100:  rdata_fmt = {24'h000000, rdata_shift[7:0]};
            3'b001:  rdata_fmt = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b101:  rdata_fmt = {16'h0000, rdata_shift[15:0]};
            default: rdata_fmt = rdata_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    stall_o = 1'b1;
                    accept  = legal;
                    state_d = legal ? StReq : StErr;
                end
            end
            StReq: begin
                stall_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_we_q    <= we_i;
                mem_addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_q <= wdata_fmt;
                mem_wstrb_q <= wstrb_fmt;
                funct3_q    <= funct3_i;
                offset_q    <= addr_i[1:0];
            end
            if ((state_q == StReq) && mem_ready_i && !mem_we_q) begin
                rdata_q <= rdata_fmt;
            end
        end
    end

    // Valid decodes straight from the state register, so reset drops it at once.
    assign mem_valid_o = (state_q == StReq);
    assign done_o      = (state_q == StResp);
    assign err_o       = (state_q == StErr);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expected values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // edge that accepts the request, with req_i dropped.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        req_i    = 1'b1;
        we_i     = we;
        funct3_i = f3;
        addr_i   = addr;
        wdata_i  = wdata;
        @(negedge clk);
        check_val({tag, " stall_idle"}, {31'd0, stall_o}, 32'd1);
        @(posedge clk);
        #1;
        req_i = 1'b0;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata, input string tag);
        issue(1'b1, f3, addr, wdata, tag);
        @(negedge clk);
        check_val({tag, " valid"}, {31'd0, mem_valid_o}, 32'd1);
        check_val({tag, " we"}, {31'd0, mem_we_o}, 32'd1);
        check_val({tag, " addr"}, mem_addr_o, {addr[31:2], 2'b00});
        check_val({tag, " wstrb"}, {28'd0, mem_wstrb_o}, {28'd0, exp_strb});
        check_val({tag, " wdata"}, mem_wdata_o, exp_wdata);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val({tag, " done"}, {31'd0, done_o}, 32'd1);
        check_val({tag, " stall_resp"}, {31'd0, stall_o}, 32'd0);
        check_val({tag, " valid_resp"}, {31'd0, mem_valid_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp, input string tag);
        issue(1'b0, f3, addr, 32'h0, tag);
        @(negedge clk);
        check_val({tag, " wstrb"}, {28'd0, mem_wstrb_o}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val({tag, " done"}, {31'd0, done_o}, 32'd1);
        check_val({tag, " rdata"}, rdata_o, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_err(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] keep_rdata, input string tag);
        issue(we, f3, addr, 32'h0, tag);
        @(negedge clk);
        check_val({tag, " err"}, {31'd0, err_o}, 32'd1);
        check_val({tag, " valid"}, {31'd0, mem_valid_o}, 32'd0);
        check_val({tag, " stall"}, {31'd0, stall_o}, 32'd0);
        check_val({tag, " rdata"}, rdata_o, keep_rdata);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val({tag, " err_gone"}, {31'd0, err_o}, 32'd0);
        check_val({tag, " valid_after"}, {31'd0, mem_valid_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        req_i       = 1'b0;
        we_i        = 1'b0;
        funct3_i    = 3'b000;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst stall", {31'd0, stall_o}, 32'd0);
        check_val("rst done", {31'd0, done_o}, 32'd0);
        check_val("rst err", {31'd0, err_o}, 32'd0);
        check_val("rst valid", {31'd0, mem_valid_o}, 32'd0);
        check_val("rst addr", mem_addr_o, 32'd0);
        check_val("rst wdata", mem_wdata_o, 32'd0);
        check_val("rst wstrb", {28'd0, mem_wstrb_o}, 32'd0);
        check_val("rst rdata", rdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset during REQ abandons the access immediately.
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, "rstreq");
        @(negedge clk);
        check_val("rstreq valid_pre", {31'd0, mem_valid_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rstreq valid_async", {31'd0, mem_valid_o}, 32'd0);
        check_val("rstreq stall_async", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rstreq no_done", {31'd0, done_o}, 32'd0);
            check_val("rstreq no_valid", {31'd0, mem_valid_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        run_store(3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw");
        run_store(3'b000, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, "sb");
        run_store(3'b001, 32'h0000_0102, 32'h0000_1234, 4'b1100, 32'h1234_1234, "sh");
        check_val("store keeps rdata", rdata_o, 32'd0);

        mem_rdata_i = 32'h80F0_7F81;
        run_load(3'b000, 32'h0000_0000, 32'hFFFF_FF81, "lb");
        run_load(3'b100, 32'h0000_0003, 32'h0000_0080, "lbu");
        run_load(3'b001, 32'h0000_0002, 32'hFFFF_80F0, "lh");
        run_load(3'b101, 32'h0000_0000, 32'h0000_7F81, "lhu");
        run_load(3'b010, 32'h0000_0008, 32'h80F0_7F81, "lw");

        // Wait states: address changes after acceptance must not leak out.
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h1122_3344;
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, "wait");
        addr_i = 32'h0000_0FFC;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("wait valid", {31'd0, mem_valid_o}, 32'd1);
            check_val("wait addr", mem_addr_o, 32'h0000_0200);
            check_val("wait stall", {31'd0, stall_o}, 32'd1);
            check_val("wait no_done", {31'd0, done_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        mem_ready_i = 1'b1;
        @(negedge clk);
        check_val("wait valid_hs", {31'd0, mem_valid_o}, 32'd1);
        check_val("wait no_done_hs", {31'd0, done_o}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("wait done", {31'd0, done_o}, 32'd1);
        check_val("wait rdata", rdata_o, 32'h1122_3344);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("wait done_once", {31'd0, done_o}, 32'd0);
        @(posedge clk);
        #1;

        run_err(1'b0, 3'b010, 32'h0000_0102, 32'h1122_3344, "lw_mis");
        run_err(1'b1, 3'b100, 32'h0000_0100, 32'h1122_3344, "sb_f3");
        run_err(1'b0, 3'b001, 32'h0000_0101, 32'h1122_3344, "lh_mis");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
